mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning memory/IO address width.
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rdy_in, input, 1, global ready; low freezes the block.
REQ-005 SHALL have port control_hazard, input, 1, ROB flush of speculative work.
REQ-006 SHALL have ports if_req (in 1) and if_addr (in ADDR_WIDTH), a 4-byte instruction fetch request.
REQ-007 SHALL have ports if_done (out 1) and if_rdata (out 32), fetch completion pulse and the fetched word.
REQ-008 SHALL have ports slb_req (in 1), slb_wr (in 1), slb_addr (in ADDR_WIDTH), slb_len (in 2: 0=1B, 1=2B, 3=4B) and slb_wdata (in 32), a load/store request.
REQ-009 SHALL have ports slb_done (out 1) and slb_rdata (out 32), load/store completion pulse and the load data.
REQ-010 SHALL have ports mem_din (in 8), mem_dout (out 8), mem_a (out ADDR_WIDTH) and mem_wr (out 1), the byte RAM/IO bus.
REQ-011 SHALL have ports io_buffer_full (in 1), UART buffer full, and busy (out 1), high when not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, IF_RD, SLB_RD, SLB_WR and DONE.
REQ-013 SHALL, in IDLE with both requests high, accept slb_req; SLB has fixed priority over IF.
REQ-014 SHALL latch the address, length, write data and direction on acceptance; requesters hold req until they see done.
REQ-015 SHALL transfer byte k at address addr+k in cycle k+1 after acceptance (k = 0..N-1, N = 4 for IF, slb_len+1 for SLB), little-endian.
REQ-016 SHALL capture the read byte from mem_din one cycle after its address is driven (1-cycle RAM read latency).
REQ-017 SHALL register read data: the word is assembled, then if_done/slb_done pulses for exactly one cycle (DONE state) with rdata valid in that cycle; read latency is N+2 cycles from the acceptance edge.
REQ-018 SHALL zero rdata bytes N..3; sign extension is not performed here.
REQ-019 SHALL drive mem_wr=1 and mem_dout=slb_wdata byte k in write cycles; write done pulses the cycle after the last byte (latency N+1).
REQ-020 SHALL ignore requests in the DONE cycle and return to IDLE afterwards; back-to-back accepts are therefore separated by one cycle.
REQ-021 SHALL drive mem_a=0, mem_wr=0 and mem_dout=0 when no byte is being transferred.
REQ-022 SHALL treat addresses with addr[17:16]==2'b11 as IO; IO writes stall per REQ-028.
REQ-023 SHALL, on control_hazard, abort IF_RD and SLB_RD (go to IDLE next edge with no done pulse and mem_wr=0); an SLB_WR in progress SHALL complete.
REQ-024 SHALL, in IDLE, ignore requests presented in the same cycle as control_hazard.
REQ-025 SHALL, while rdy_in is low, hold all state and force mem_wr=0; a byte whose read data was due in that cycle is reissued on resume.

Reset
REQ-026 SHALL, while rst_in is low, immediately set state IDLE, if_done=0, slb_done=0, if_rdata=0, slb_rdata=0, mem_a=0, mem_wr=0, mem_dout=0 and busy=0.
REQ-027 SHALL abandon any transfer on reset mid-operation; no done pulse follows reset release.

Configuration
REQ-028 SHALL, with MEM_CTRL_IO_STALL_EN defined, hold the current IO write byte (mem_wr=0, byte index frozen) while io_buffer_full=1 and resume when it drops; without the macro, io_buffer_full SHALL be ignored.

Verification
REQ-029 SHALL pass: if_req at 0x100 with RAM 13 05 00 00 -> if_done in cycle 6 after accept, if_rdata=0x00000513.
REQ-030 SHALL pass: if_req and slb_req (read, len=1, 0x200 = FE FF) high together -> SLB served first, slb_rdata=0x0000FFFE, then IF accepted after DONE.
REQ-031 SHALL pass: slb write len=3 wdata=0xDEADBEEF at 0x400 -> mem_wr bytes EF, BE, AD, DE at 0x400..0x403, slb_done in cycle 5.
REQ-032 SHALL pass: control_hazard in IF_RD cycle 2 -> IDLE next cycle, no if_done; a concurrent SLB_WR still completes.
REQ-033 SHALL pass (macro on): 1-byte write 0x41 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr low those cycles, then one write of 0x41; macro off -> write in cycle 1.
REQ-034 SHALL pass: rst_in low during SLB_RD -> all outputs 0 immediately, no slb_done after release.

Source files
------------

// File: rtl/mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_ctrl                                                        |
// | Purpose  : Byte-serial memory controller shared by instruction fetch (IF)  |
// |            and the load/store buffer (SLB). A request is accepted in IDLE  |
// |            (SLB wins over IF), then bytes are moved one per cycle over a   |
// |            byte-wide RAM/IO bus with 1-cycle read latency. Completion is a |
// |            single-cycle done pulse issued from the DONE state.             |
// | Ports    : clk_in, rst_in (async, active-low), rdy_in (global stall),      |
// |            control_hazard (flush of speculative reads),                    |
// |            if_req/if_addr -> if_done/if_rdata (4-byte fetch),              |
// |            slb_req/slb_wr/slb_addr/slb_len/slb_wdata -> slb_done/slb_rdata,|
// |            mem_din/mem_dout/mem_a/mem_wr (byte bus), io_buffer_full,       |
// |            busy (high whenever the FSM is not IDLE).                       |
// | Options  : MEM_CTRL_IO_STALL_EN -- when defined, IO writes                 |
// |            (addr[17:16]==2'b11) wait while io_buffer_full is high.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  control_hazard,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_rdata,
  input  logic                  slb_req,
  input  logic                  slb_wr,
  input  logic [ADDR_WIDTH-1:0] slb_addr,
  input  logic [1:0]            slb_len,
  input  logic [31:0]           slb_wdata,
  output logic                  slb_done,
  output logic [31:0]           slb_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    SLB_RD = 3'd2,
    SLB_WR = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            len_q, len_d;          // bytes-1 of the transfer
  logic [31:0]           wdata_q, wdata_d;
  logic                  slb_q, slb_d;          // transfer owned by SLB
  logic [2:0]            cnt_q, cnt_d;          // byte index on the bus
  logic [31:0]           buf_q, buf_d;          // read word under assembly
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic [31:0]           slb_rdata_q, slb_rdata_d;

  logic [2:0]            w_last;                // index of last byte
  logic [2:0]            w_n;                   // number of bytes
  logic [1:0]            w_rd_idx;              // byte slot being captured
  logic [1:0]            w_wr_idx;              // byte slot being written
  logic [2:0]            w_hold_idx;            // address reissued while stalled
  logic                  w_io_stall;

  assign w_last     = {1'b0, len_q};
  assign w_n        = w_last + 3'd1;
  assign w_rd_idx   = 2'(cnt_q - 3'd1);
  assign w_wr_idx   = cnt_q[1:0];
  assign w_hold_idx = (cnt_q == 3'd0) ? 3'd0 : (cnt_q - 3'd1);

`ifdef MEM_CTRL_IO_STALL_EN
  assign w_io_stall = (addr_q[17:16] == 2'b11) && io_buffer_full;
`else
  logic io_full_unused;
  assign io_full_unused = io_buffer_full;
  assign w_io_stall     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    slb_d       = slb_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    if_rdata_d  = if_rdata_q;
    slb_rdata_d = slb_rdata_q;
    mem_a       = '0;
    mem_wr      = 1'b0;
    mem_dout    = 8'h00;

    if (!rdy_in) begin
      // Frozen. In a read, point the RAM at the byte whose data would have
      // been captured this cycle so that it is on mem_din when we resume.
      if ((state_q == IF_RD) || (state_q == SLB_RD)) begin
        mem_a = addr_q + {{(ADDR_WIDTH-3){1'b0}}, w_hold_idx};
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!control_hazard) begin
            if (slb_req) begin
              addr_d  = slb_addr;
              len_d   = slb_len;
              wdata_d = slb_wdata;
              slb_d   = 1'b1;
              cnt_d   = 3'd0;
              buf_d   = 32'h0;
              state_d = slb_wr ? SLB_WR : SLB_RD;
            end else if (if_req) begin
              addr_d  = if_addr;
              len_d   = 2'd3;
              slb_d   = 1'b0;
              cnt_d   = 3'd0;
              buf_d   = 32'h0;
              state_d = IF_RD;
            end
          end
        end

        IF_RD, SLB_RD: begin
          if (control_hazard) begin
            state_d = IDLE;
          end else begin
            // Address for byte cnt goes out while data for byte cnt-1 arrives.
            if (cnt_q < w_n) begin
              mem_a = addr_q + {{(ADDR_WIDTH-3){1'b0}}, cnt_q};
            end
            if (cnt_q != 3'd0) begin
              buf_d[{w_rd_idx, 3'b000} +: 8] = mem_din;
            end
            if (cnt_q == w_n) begin
              state_d = DONE;
              if (slb_q) begin
                slb_rdata_d = buf_d;
              end else begin
                if_rdata_d = buf_d;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end

        SLB_WR: begin
          // Writes are never flushed; only a full IO buffer can hold them.
          if (!w_io_stall) begin
            mem_wr   = 1'b1;
            mem_a    = addr_q + {{(ADDR_WIDTH-3){1'b0}}, cnt_q};
            mem_dout = wdata_q[{w_wr_idx, 3'b000} +: 8];
            if (cnt_q == w_last) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= 2'd0;
      wdata_q     <= 32'h0;
      slb_q       <= 1'b0;
      cnt_q       <= 3'd0;
      buf_q       <= 32'h0;
      if_rdata_q  <= 32'h0;
      slb_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      slb_q       <= slb_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      if_rdata_q  <= if_rdata_d;
      slb_rdata_q <= slb_rdata_d;
    end
  end

  assign if_done   = (state_q == DONE) && !slb_q;
  assign slb_done  = (state_q == DONE) && slb_q;
  assign if_rdata  = if_rdata_q;
  assign slb_rdata = slb_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
